// File: rtl/calculator_bcd_reader.sv
// Sequential two's-complement to packed-BCD converter (double-dabble) for the display path.
// Optional CALC_BCD_BLANK_EN: leading zero digits are written as 4'hF on completion.
module calculator_bcd_reader #(
    parameter int BITS   = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [BITS-1:0]       accum,
    output logic                  busy,
    output logic                  done,
    output logic                  negative,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CW = $clog2(BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    typedef enum logic [1:0] {IDLE, ABS, SHIFT, DONE} state_t;

    state_t              state, state_next;
    logic [BITS-1:0]     bin_reg, bin_next;
    logic [4*DIGITS-1:0] dig_reg, dig_next, dig_adj, dig_final;
    logic [CW-1:0]       cnt, cnt_next;
    logic                neg_int, neg_next;
    logic                ovf_int, ovf_next;
    logic                done_next;

    assign busy = (state != IDLE);

    always_comb begin
        dig_adj = dig_reg;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_reg[4*i +: 4] >= 4'd5)
                dig_adj[4*i +: 4] = dig_reg[4*i +: 4] + 4'd3;
        end
    end

`ifdef CALC_BCD_BLANK_EN
    // Blank zeros above the top nonzero digit; units digit always shown.
    always_comb begin
        logic lead;
        dig_final = dig_reg;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && !ovf_int && dig_reg[4*i +: 4] == 4'd0)
                dig_final[4*i +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
    end
`else
    assign dig_final = dig_reg;
`endif

    always_comb begin
        state_next = state;
        bin_next   = bin_reg;
        dig_next   = dig_reg;
        cnt_next   = cnt;
        neg_next   = neg_int;
        ovf_next   = ovf_int;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    bin_next   = accum;
                    dig_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = ABS;
                end
            end
            ABS: begin
                neg_next = bin_reg[BITS-1];
                if (bin_reg[BITS-1])
                    bin_next = ~bin_reg + BITS'(1);
                state_next = SHIFT;
            end
            SHIFT: begin
                {dig_next, bin_next} = {dig_adj[4*DIGITS-2:0], bin_reg, 1'b0};
                ovf_next = ovf_int | dig_adj[4*DIGITS-1];
                cnt_next = cnt + CW'(1);
                if (cnt == LAST)
                    state_next = DONE;
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            bin_reg  <= '0;
            dig_reg  <= '0;
            cnt      <= '0;
            neg_int  <= 1'b0;
            ovf_int  <= 1'b0;
            done     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
            bcd_out  <= '0;
        end else begin
            state   <= state_next;
            bin_reg <= bin_next;
            dig_reg <= dig_next;
            cnt     <= cnt_next;
            neg_int <= neg_next;
            ovf_int <= ovf_next;
            done    <= done_next;
            if (state == DONE) begin
                bcd_out  <= dig_final;
                negative <= neg_int;
                overflow <= ovf_int;
            end
        end
    end

endmodule
